// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-wide memory controller.
//   ADDR_LEN / REG_LEN : default byte-address width and data-word width
//   MEM_BYTE/HALF/WORD : MEM access size codes (2'b11 is treated as word)
//   state_e            : controller FSM states
//   size_to_len()      : size code -> number of bytes to sequence
package mem_ctrl_pkg;

  localparam int unsigned ADDR_LEN = 32;
  localparam int unsigned REG_LEN  = 32;
  localparam int unsigned BYTE_LEN = 8;
  localparam int unsigned CNT_W    = 3;

  localparam logic [REG_LEN-1:0] ZERO_WORD = '0;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_RD  = 2'd1,
    ST_MEM_RD = 2'd2,
    ST_MEM_WR = 2'd3
  } state_e;

  function automatic logic [CNT_W-1:0] size_to_len(input logic [1:0] size);
    case (size)
      MEM_BYTE: return CNT_W'(1);
      MEM_HALF: return CNT_W'(2);
      default:  return CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Core-side request bus of the memory controller.
//   IF group : if_req/if_addr/if_jump from the fetch stage; if_busy/if_ready/if_inst back
//   MEM group: mem_req/we/size/addr/wdata from the MEM stage; mem_ready/mem_rdata back
//   master   : the core (drives requests); slave: the controller
interface mem_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_LEN
) ();

  logic               if_req;
  logic [ADDR_W-1:0]  if_addr;
  logic               if_jump;
  logic               if_busy;
  logic               if_ready;
  logic [REG_LEN-1:0] if_inst;

  logic               mem_req;
  logic               mem_we;
  logic [1:0]         mem_size;
  logic [ADDR_W-1:0]  mem_addr;
  logic [REG_LEN-1:0] mem_wdata;
  logic               mem_ready;
  logic [REG_LEN-1:0] mem_rdata;

  modport master (
    output if_req, if_addr, if_jump, mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    input  if_busy, if_ready, if_inst, mem_ready, mem_rdata
  );

  modport slave (
    input  if_req, if_addr, if_jump, mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    output if_busy, if_ready, if_inst, mem_ready, mem_rdata
  );

endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates instruction fetch and MEM-stage accesses onto a
// byte-wide synchronous RAM, sequencing 1/2/4-byte accesses one byte per cycle.
//   clk, rst   : clock, synchronous active-high reset
//   core       : mem_ctrl_if.slave request bus (IF and MEM requesters)
//   ram_din_i  : RAM read byte, valid the cycle after its address
//   ram_dout_o : RAM write byte
//   ram_a_o    : RAM byte address (holds last value when idle)
//   ram_wr_o   : RAM write enable
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_LEN,
  parameter bit          IF_PRIORITY = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  mem_ctrl_if.slave           core,
  input  logic [BYTE_LEN-1:0] ram_din_i,
  output logic [BYTE_LEN-1:0] ram_dout_o,
  output logic [ADDR_W-1:0]   ram_a_o,
  output logic                ram_wr_o
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [REG_LEN-1:0]  wdata_q, wdata_d;
  logic [REG_LEN-1:0]  rbuf_q, rbuf_d;
  logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
  logic [BYTE_LEN-1:0] ram_dout_q, ram_dout_d;
  logic                ram_wr_q, ram_wr_d;
  logic                if_busy_q, if_busy_d;
  logic                if_ready_q, if_ready_d;
  logic [REG_LEN-1:0]  if_inst_q, if_inst_d;
  logic                mem_ready_q, mem_ready_d;
  logic [REG_LEN-1:0]  mem_rdata_q, mem_rdata_d;

  // A request seen while its own ready is still high was just served.
  logic if_take, mem_take, go_if, go_mem, abort;
  assign if_take  = core.if_req  & ~if_ready_q;
  assign mem_take = core.mem_req & ~mem_ready_q;
  assign go_if    = if_take & (IF_PRIORITY | ~mem_take);
  assign go_mem   = mem_take & ~go_if;
  assign abort    = (state_q == ST_IF_RD) && core.if_jump;

  // cnt_q is the edge index k since accept; reads capture two edges behind issue.
  logic       issue, capture, rd_done, wr_done;
  logic [1:0] rd_lane, wr_lane;
  assign issue   = (cnt_q < len_q);
  assign capture = (cnt_q >= CNT_W'(2));
  assign rd_done = (cnt_q == len_q + CNT_W'(1));
  assign wr_done = (cnt_q == len_q);
  assign rd_lane = 2'(cnt_q - CNT_W'(2));
  assign wr_lane = 2'(cnt_q);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_busy_q   <= 1'b0;
      if_ready_q  <= 1'b0;
      if_inst_q   <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_busy_q   <= if_busy_d;
      if_ready_q  <= if_ready_d;
      if_inst_q   <= if_inst_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (go_mem)     state_d = core.mem_we ? ST_MEM_WR : ST_MEM_RD;
        else if (go_if) state_d = ST_IF_RD;
      end
      ST_IF_RD:  if (abort || rd_done) state_d = ST_IDLE;
      ST_MEM_RD: if (rd_done)          state_d = ST_IDLE;
      ST_MEM_WR: if (wr_done)          state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Byte sequencer, lane capture and registered outputs.
  always_comb begin
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    if_busy_d   = (state_d == ST_IF_RD);
    case (state_q)
      ST_IDLE: begin
        if (go_mem || go_if) begin
          cnt_d  = CNT_W'(1);
          rbuf_d = ZERO_WORD;
          if (go_mem) begin
            len_d      = size_to_len(core.mem_size);
            base_d     = core.mem_addr;
            wdata_d    = core.mem_wdata;
            ram_a_d    = core.mem_addr;
            ram_dout_d = core.mem_wdata[BYTE_LEN-1:0];
            ram_wr_d   = core.mem_we;
          end else begin
            len_d   = CNT_W'(4);
            base_d  = core.if_addr;
            ram_a_d = core.if_addr;
          end
        end
      end
      ST_IF_RD, ST_MEM_RD: begin
        if (!abort) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (issue) ram_a_d = base_q + ADDR_W'(cnt_q);
          for (int l = 0; l < 4; l++) begin
            if (capture && rd_lane == 2'(l)) rbuf_d[l*8 +: 8] = ram_din_i;
          end
          if (rd_done) begin
            if (state_q == ST_IF_RD) begin
              if_inst_d  = rbuf_d;
              if_ready_d = 1'b1;
            end else begin
              mem_rdata_d = rbuf_d;
              mem_ready_d = 1'b1;
            end
          end
        end
      end
      ST_MEM_WR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (issue) begin
          ram_a_d  = base_q + ADDR_W'(cnt_q);
          ram_wr_d = 1'b1;
          for (int l = 0; l < 4; l++) begin
            if (wr_lane == 2'(l)) ram_dout_d = wdata_q[l*8 +: 8];
          end
        end
        if (wr_done) mem_ready_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign core.if_busy   = if_busy_q;
  assign core.if_ready  = if_ready_q;
  assign core.if_inst   = if_inst_q;
  assign core.mem_ready = mem_ready_q;
  assign core.mem_rdata = mem_rdata_q;
  assign ram_a_o        = ram_a_q;
  assign ram_dout_o     = ram_dout_q;
  assign ram_wr_o       = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed cases plus randomized IF/MEM traffic against
// a byte-array reference memory; a negedge monitor checks every ready pulse and RAM write.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32), .IF_PRIORITY(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .core       (bus),
    .ram_din_i  (ram_din),
    .ram_dout_o (ram_dout),
    .ram_a_o    (ram_a),
    .ram_wr_o   (ram_wr)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Background RAM contents, with the bytes the directed cases rely on.
  function automatic logic [7:0] bg_byte(input int a);
    logic [15:0] x;
    x = 16'(a);
    case (x)
      16'h0100: return 8'h13;
      16'h0101: return 8'h05;
      16'h0102: return 8'h00;
      16'h0103: return 8'h00;
      16'h0200: return 8'h93;
      16'h0201: return 8'h00;
      16'h0202: return 8'h10;
      16'h0203: return 8'h00;
      16'h1002: return 8'h34;
      16'h1003: return 8'hFF;
      default:  return 8'((a * 29) ^ (a >> 7));
    endcase
  endfunction

  // Synchronous byte RAM (64 KiB, address wraps on the low 16 bits).
  logic [7:0] ram [0:65535];
  bit ram_init_done;
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 65536; i++) ram[i] <= bg_byte(i);
      ram_init_done <= 1'b1;
    end else if (ram_wr) begin
      ram[ram_a[15:0]] <= ram_dout;
    end
    ram_din <= ram[ram_a[15:0]];
  end

  // Reference model state and scoreboards.
  logic [7:0] ref_mem [0:65535];

  typedef struct {
    bit          is_if;
    bit          chk;
    logic [31:0] data;
    int          issue;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
  endtask

  function automatic int size_len(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[16'(a + 32'(k))];
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input int n);
    wr_t w;
    for (int k = 0; k < n; k++) begin
      ref_mem[16'(a + 32'(k))] = wd[8*k +: 8];
      w.a = a + 32'(k);
      w.d = wd[8*k +: 8];
      wr_q.push_back(w);
    end
  endtask

  task automatic push_exp(input bit is_if, input bit chk, input logic [31:0] d, input int lat);
    exp_t e;
    e.is_if = is_if;
    e.chk   = chk;
    e.data  = d;
    e.issue = cyc;
    e.lat   = lat;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every ready pulse and every RAM write against the scoreboards.
  always @(negedge clk) begin
    exp_t e;
    wr_t  w;
    if (bus.if_ready || bus.mem_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_ready: if_ready=%0b mem_ready=%0b with nothing outstanding",
                 bus.if_ready, bus.mem_ready);
      end else begin
        e = exp_q.pop_front();
        check("ready_port_is_if", 32'(bus.if_ready), 32'(e.is_if));
        if (e.chk) check(e.is_if ? "if_inst" : "mem_rdata",
                         e.is_if ? bus.if_inst : bus.mem_rdata, e.data);
        if (e.lat >= 0) check("latency", 32'(cyc - e.issue - 1), 32'(e.lat));
      end
    end
    if (ram_wr) begin
      if (wr_q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_write: addr 0x%08h data 0x%02h", ram_a, ram_dout);
      end else begin
        w = wr_q.pop_front();
        check("wr_addr", ram_a, w.a);
        check("wr_data", 32'(ram_dout), 32'(w.d));
      end
    end
  end

  task automatic wait_ready(input bit is_if);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (is_if ? bus.if_ready : bus.mem_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL %s_timeout: no ready within 40 cycles, required a pulse", is_if ? "if" : "mem");
    end
  endtask

  task automatic drive_mem(input bit we, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd);
    bus.mem_req   = 1'b1;
    bus.mem_we    = we;
    bus.mem_size  = sz;
    bus.mem_addr  = a;
    bus.mem_wdata = wd;
  endtask

  // MEM access; expected data from the model unless a constant is supplied.
  task automatic do_mem(input bit we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, input bit use_c,
                        input logic [31:0] cval);
    int n;
    n = size_len(sz);
    @(negedge clk);
    drive_mem(we, sz, a, wd);
    if (we) begin
      ref_store(a, wd, n);
      push_exp(1'b0, 1'b0, '0, n);
    end else begin
      push_exp(1'b0, 1'b1, use_c ? cval : ref_load(a, n), n + 1);
    end
    wait_ready(1'b0);
    if (hold) @(negedge clk);
    bus.mem_req = 1'b0;
  endtask

  task automatic do_if(input logic [31:0] a, input bit hold, input bit use_c,
                       input logic [31:0] cval);
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    push_exp(1'b1, 1'b1, use_c ? cval : ref_load(a, 4), 5);
    wait_ready(1'b1);
    if (hold) @(negedge clk);
    bus.if_req = 1'b0;
  endtask

  // Both requesters on the same edge: MEM is served first, IF one edge after mem_ready.
  task automatic do_pair(input bit we, input logic [1:0] sz, input logic [31:0] ma,
                         input logic [31:0] wd, input logic [31:0] ia, input bit hold);
    int n, lm;
    n = size_len(sz);
    lm = we ? n : n + 1;
    @(negedge clk);
    drive_mem(we, sz, ma, wd);
    bus.if_req  = 1'b1;
    bus.if_addr = ia;
    if (we) begin
      ref_store(ma, wd, n);
      push_exp(1'b0, 1'b0, '0, lm);
    end else begin
      push_exp(1'b0, 1'b1, ref_load(ma, n), lm);
    end
    push_exp(1'b1, 1'b1, ref_load(ia, 4), lm + 6);
    wait_ready(1'b0);
    if (hold) @(negedge clk);
    bus.mem_req = 1'b0;
    wait_ready(1'b1);
    bus.if_req = 1'b0;
  endtask

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
    return 32'h0000_3000 + 32'($urandom_range(0, 63));
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = bg_byte(i);
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_jump = 1'b0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_size = 2'b00;
    bus.mem_addr = '0; bus.mem_wdata = '0;

    repeat (3) @(negedge clk);
    check("rst_if_busy",   32'(bus.if_busy),   32'd0);
    check("rst_if_ready",  32'(bus.if_ready),  32'd0);
    check("rst_if_inst",   bus.if_inst,        32'd0);
    check("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    check("rst_mem_rdata", bus.mem_rdata,      32'd0);
    check("rst_ram_wr",    32'(ram_wr),        32'd0);
    check("rst_ram_a",     ram_a,              32'd0);
    check("rst_ram_dout",  32'(ram_dout),      32'd0);
    rst = 1'b0;

    // Directed cases.
    do_if(32'h0000_0100, 1'b0, 1'b1, 32'h0000_0513);
    do_mem(1'b0, 2'b00, 32'h0000_1003, '0, 1'b1, 1'b1, 32'h0000_00FF);
    do_mem(1'b0, 2'b01, 32'h0000_1002, '0, 1'b0, 1'b1, 32'h0000_FF34);
    do_mem(1'b1, 2'b10, 32'h0000_2000, 32'hDEAD_BEEF, 1'b1, 1'b0, '0);
    do_mem(1'b0, 2'b10, 32'h0000_2000, '0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    do_mem(1'b0, 2'b11, 32'hFFFF_FFFE, '0, 1'b0, 1'b0, '0);
    do_pair(1'b0, 2'b10, 32'h0000_2000, '0, 32'h0000_0100, 1'b0);

    // Jump during the third IF_RD cycle, retargeting to 0x200.
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0100;
    @(negedge clk);
    check("busy_in_if_rd", 32'(bus.if_busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    bus.if_jump = 1'b1;
    bus.if_addr = 32'h0000_0200;
    push_exp(1'b1, 1'b1, 32'h0010_0093, 6);
    @(negedge clk);
    bus.if_jump = 1'b0;
    check("busy_after_jump",  32'(bus.if_busy),  32'd0);
    check("ready_after_jump", 32'(bus.if_ready), 32'd0);
    wait_ready(1'b1);
    bus.if_req = 1'b0;

    // Reset after two bytes of a word store.
    @(negedge clk);
    drive_mem(1'b1, 2'b10, 32'h0000_2000, 32'h1122_3344);
    ref_store(32'h0000_2000, 32'h0000_3344, 2);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_wr_ram_wr",    32'(ram_wr),        32'd0);
    check("rst_mid_wr_mem_ready", 32'(bus.mem_ready), 32'd0);
    check("rst_mid_wr_busy",      32'(bus.if_busy),   32'd0);
    bus.mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_mem(1'b0, 2'b10, 32'h0000_2000, '0, 1'b0, 1'b1, 32'hDEAD_3344);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: do_if(rnd_addr() & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), 1'b0, '0);
        1: do_mem(1'b0, 2'($urandom_range(0, 3)), rnd_addr(), '0,
                  1'($urandom_range(0, 1)), 1'b0, '0);
        2: do_mem(1'b1, 2'($urandom_range(0, 3)), rnd_addr(), $urandom,
                  1'($urandom_range(0, 1)), 1'b0, '0);
        default: do_pair(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rnd_addr(),
                         $urandom, rnd_addr() & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
      endcase
    end

    repeat (10) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("wr_q_drained",  32'(wr_q.size()),  32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
